// File: rtl/bcd_disp_pkg.sv
// Shared types and constants for the BCD display path.
// Frame is six packed BCD digits, most significant first.
package bcd_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [7:0] ASCII_ZERO     = 8'h30;
  localparam logic [7:0] DEF_CHAR_BLANK = 8'h20;
  localparam logic [7:0] DEF_CHAR_BAD   = 8'h3F;
  localparam int         NUM_DIGITS     = 6;
  localparam logic [2:0] LAST_IDX       = 3'(NUM_DIGITS - 1);

  // True when any nibble of a packed value is not a decimal digit.
  function automatic logic any_bad(input logic [23:0] v);
    logic b;
    b = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[i*4 +: 4] > 4'd9) b = 1'b1;
    end
    return b;
  endfunction

endpackage

// File: rtl/bcd_digit_to_ascii.sv
// One BCD nibble to one display character.
// Blanking applies only to a decimal zero with blank enable set.
module bcd_digit_to_ascii
  import bcd_disp_pkg::*;
#(
  parameter logic [7:0] CHAR_BLANK = DEF_CHAR_BLANK,
  parameter logic [7:0] CHAR_BAD   = DEF_CHAR_BAD
) (
  input  logic [3:0] nib_i,
  input  logic       blank_en_i,
  output logic [7:0] char_o,
  output logic       bad_o
);

  // Bad digits win over blanking; zero is blanked only when enabled.
  always_comb begin
    bad_o  = (nib_i > 4'd9);
    char_o = ASCII_ZERO + {4'h0, nib_i};
    if (bad_o) begin
      char_o = CHAR_BAD;
    end else if (blank_en_i && (nib_i == 4'd0)) begin
      char_o = CHAR_BLANK;
    end
  end

endmodule

// File: rtl/bcd_char_streamer.sv
// Streams a captured 6-digit BCD value as ASCII, MSD first.
// Next character is precomputed so every output is registered.
module bcd_char_streamer
  import bcd_disp_pkg::*;
#(
  parameter bit         BLANK_LEADING = 1'b1,
  parameter logic [7:0] CHAR_BLANK    = DEF_CHAR_BLANK,
  parameter logic [7:0] CHAR_BAD      = DEF_CHAR_BAD
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [23:0] iBCD,
  input  logic        iSTART,
  output logic        oBUSY,
  output logic [7:0]  oCHAR,
  output logic        oVALID,
  input  logic        iREADY,
  output logic        oLAST,
  output logic        oDONE,
  output logic        oERR
);

  state_e      state_q, state_d;
  logic [23:0] sr_q, sr_d;
  logic [2:0]  idx_q, idx_d;
  logic        zrun_q, zrun_d;
  logic [7:0]  char_q, char_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;

  logic [3:0]  cv_nib;
  logic        cv_blank;
  logic [7:0]  cv_char;
  logic        cv_bad;
  logic        cv_zero;
  logic [2:0]  idx_nxt;

  // Select the digit that becomes the next character: the incoming
  // top nibble at capture, else the nibble below the current one.
  // zrun_q means every digit emitted so far in this frame was blanked.
  always_comb begin
    idx_nxt  = idx_q + 3'd1;
    cv_nib   = sr_q[19:16];
    cv_blank = zrun_q && (idx_nxt < LAST_IDX);
    if (state_q == ST_IDLE) begin
      cv_nib   = iBCD[23:20];
      cv_blank = BLANK_LEADING;
    end
  end

  bcd_digit_to_ascii #(
    .CHAR_BLANK (CHAR_BLANK),
    .CHAR_BAD   (CHAR_BAD)
  ) u_conv (
    .nib_i      (cv_nib),
    .blank_en_i (cv_blank),
    .char_o     (cv_char),
    .bad_o      (cv_bad)
  );

  assign cv_zero = !cv_bad && (cv_nib == 4'd0) && cv_blank;

  // Frame sequencing: capture, one character per transfer, done pulse.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    idx_d   = idx_q;
    zrun_d  = zrun_q;
    char_d  = char_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (iSTART) begin
          sr_d    = iBCD;
          idx_d   = 3'd0;
          zrun_d  = cv_zero;
          err_d   = any_bad(iBCD);
          char_d  = cv_char;
          valid_d = 1'b1;
          last_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (valid_q && iREADY) begin
          sr_d = {sr_q[19:0], 4'h0};
          if (idx_q == LAST_IDX) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            idx_d  = idx_nxt;
            zrun_d = cv_zero;
            char_d = cv_char;
            last_d = (idx_nxt == LAST_IDX);
          end
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= ST_IDLE;
      sr_q    <= 24'h0;
      idx_q   <= 3'd0;
      zrun_q  <= 1'b0;
      char_q  <= 8'h00;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      idx_q   <= idx_d;
      zrun_q  <= zrun_d;
      char_q  <= char_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign oBUSY  = busy_q;
  assign oCHAR  = char_q;
  assign oVALID = valid_q;
  assign oLAST  = last_q;
  assign oDONE  = done_q;
  assign oERR   = err_q;

endmodule
